// File: rtl/mul_tb_pkg.sv
// Shared types and sizing constants for the mul25 datapath and its serial result port.
package mul_tb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned MUL25_PRODUCT_W = 50;
  localparam int unsigned MUL25_COLS      = 49;

endpackage

// File: rtl/result_piso.sv
// Parallel-in/serial-out register: captures a full word, then shifts it toward the output end.
module result_piso #(
  parameter int unsigned WIDTH     = 50,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  output logic             sout
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  // Load wins over shift; the controller never asserts both, but priority keeps it defined.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift_en) begin
      shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  if (LSB_FIRST) begin : g_lsb
    assign sout = shreg_q[0];
  end else begin : g_msb
    assign sout = shreg_q[WIDTH-1];
  end

endmodule

// File: rtl/product_serializer.sv
// Captures the compressor's parallel product and streams it out one bit per valid/ready beat.
module product_serializer
  import mul_tb_pkg::*;
#(
  parameter int unsigned WIDTH     = MUL25_PRODUCT_W,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            in_shift;
  logic            accept;
  logic            beat;
  logic            at_last;
  logic            piso_sout;

  assign in_shift = (state_q == SHIFT);
  assign accept   = !in_shift && load;
  assign beat     = in_shift && sout_ready;
  assign at_last  = (cnt_q == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (sout_ready) begin
            if (at_last) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  result_piso #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .din      (din),
    .shift_en (beat),
    .sout     (piso_sout)
  );

  // Every output is a pure decode of state/counter/shift register; nothing passes through from inputs.
  assign load_ready = !in_shift;
  assign busy       = in_shift;
  assign sout_valid = in_shift;
  assign sout_last  = in_shift && at_last;
  assign sout       = in_shift && piso_sout;

  cnt_in_range_a : assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= LastCnt);
  idle_cnt_zero_a : assert property (@(posedge clk) disable iff (!rst_n)
                                     (state_q == IDLE) |-> (cnt_q == '0));

endmodule

// File: tb/tb_product_serializer.sv
// Directed bench: table of product words plus hand sequences for stalls, reset and late loads.
module tb_product_serializer;

  localparam logic [49:0] Ones50 = 50'h3FFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [49:0] din;
  logic        sout_ready;
  logic        load_ready, sout, sout_valid, sout_last, busy;
  logic        load_ready_m, sout_m, sout_valid_m, sout_last_m, busy_m;

  product_serializer #(.WIDTH(50), .LSB_FIRST(1'b1)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .din        (din),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  product_serializer #(.WIDTH(50), .LSB_FIRST(1'b0)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .din        (din),
    .load_ready (load_ready_m),
    .sout       (sout_m),
    .sout_valid (sout_valid_m),
    .sout_ready (sout_ready),
    .sout_last  (sout_last_m),
    .busy       (busy_m)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results of the most recent send_word.
  logic [49:0] got_lsb, got_msb;
  logic        first_lsb, first_msb;
  int          beats, last_pos, last_cnt, busy_cyc, stab_err;
  logic        timed_out;

  task automatic send_word(input logic [49:0] d, input bit stall, input bit inject);
    logic [3:0] pat;
    logic       prev_hold, prev_sout, prev_last;
    int         k;
    pat = 4'b1001;  // ready sequence 1,0,0,1 from bit 0 upward
    got_lsb = '0; got_msb = '0; beats = 0; last_pos = -1; last_cnt = 0;
    busy_cyc = 0; stab_err = 0; timed_out = 1'b0; prev_hold = 1'b0;
    prev_sout = 1'b0; prev_last = 1'b0; first_lsb = 1'bx; first_msb = 1'bx;
    @(negedge clk);
    load = 1'b1; din = d; sout_ready = 1'b0;
    @(negedge clk);
    load = 1'b0; din = '0;
    k = 0;
    while (beats < 50) begin
      if (k >= 400) begin
        timed_out = 1'b1;
        break;
      end
      sout_ready = stall ? pat[k % 4] : 1'b1;
      load = inject && (beats == 10);
      din  = (inject && (beats == 10)) ? Ones50 : '0;
      if (busy) busy_cyc++;
      if (!sout_valid || !sout_valid_m) stab_err++;
      if (prev_hold && (sout !== prev_sout || sout_last !== prev_last)) stab_err++;
      prev_hold = !sout_ready;
      prev_sout = sout;
      prev_last = sout_last;
      if (sout_ready) begin
        if (beats == 0) begin
          first_lsb = sout;
          first_msb = sout_m;
        end
        got_lsb[beats] = sout;
        got_msb = {got_msb[48:0], sout_m};
        if (sout_last) begin
          last_cnt++;
          last_pos = beats;
        end
        beats++;
      end
      k++;
      @(negedge clk);
    end
    load = 1'b0;
    din = '0;
    sout_ready = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check(name, {59'd0, load_ready, busy, sout_valid, sout_last, sout}, 64'b10000);
    check({name, "_msb"}, {59'd0, load_ready_m, busy_m, sout_valid_m, sout_last_m, sout_m},
          64'b10000);
  endtask

  typedef struct {
    logic [49:0] din;
    logic        first_lsb;
    logic        first_msb;
    int          ones;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{din: 50'h1,             first_lsb: 1'b1, first_msb: 1'b0, ones: 1};
    vecs[1] = '{din: 50'h2AAAAAAAAAAAA, first_lsb: 1'b0, first_msb: 1'b1, ones: 25};
    vecs[2] = '{din: Ones50,            first_lsb: 1'b1, first_msb: 1'b1, ones: 50};
    vecs[3] = '{din: 50'h3FFFFFC000001, first_lsb: 1'b1, first_msb: 1'b1, ones: 25};
    vecs[4] = '{din: 50'h5,             first_lsb: 1'b1, first_msb: 1'b0, ones: 2};

    rst_n = 1'b0; load = 1'b1; din = Ones50; sout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_outputs");
    load = 1'b0; din = '0; sout_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");

    for (int i = 0; i < 5; i++) begin
      send_word(vecs[i].din, 1'b0, 1'b0);
      check($sformatf("v%0d_timeout", i), {63'd0, timed_out}, 64'd0);
      check($sformatf("v%0d_lsb_word", i), {14'd0, got_lsb}, {14'd0, vecs[i].din});
      check($sformatf("v%0d_msb_word", i), {14'd0, got_msb}, {14'd0, vecs[i].din});
      check($sformatf("v%0d_first_lsb", i), {63'd0, first_lsb}, {63'd0, vecs[i].first_lsb});
      check($sformatf("v%0d_first_msb", i), {63'd0, first_msb}, {63'd0, vecs[i].first_msb});
      check($sformatf("v%0d_ones", i), 64'($countones(got_lsb)), 64'(vecs[i].ones));
      check($sformatf("v%0d_last_pos", i), 64'(last_pos), 64'd49);
      check($sformatf("v%0d_last_cnt", i), 64'(last_cnt), 64'd1);
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_cyc), 64'd50);
      check($sformatf("v%0d_valid_stable", i), 64'(stab_err), 64'd0);
      check_idle($sformatf("v%0d_idle_after", i));
    end

    // Ready asserted while idle must not start anything.
    sout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("ready_in_idle");
    sout_ready = 1'b0;

    // Backpressure with ready pattern 1,0,0,1.
    send_word(Ones50, 1'b1, 1'b0);
    check("bp_timeout", {63'd0, timed_out}, 64'd0);
    check("bp_word", {14'd0, got_lsb}, {14'd0, Ones50});
    check("bp_beats", 64'(beats), 64'd50);
    check("bp_stable", 64'(stab_err), 64'd0);
    check("bp_last_pos", 64'(last_pos), 64'd49);
    check("bp_last_cnt", 64'(last_cnt), 64'd1);
    check_idle("bp_idle_after");

    // Load while shifting is ignored.
    send_word(50'h5, 1'b0, 1'b1);
    check("late_load_lsb", {14'd0, got_lsb}, 64'h5);
    check("late_load_msb", {14'd0, got_msb}, 64'h5);
    check("late_load_busy", 64'(busy_cyc), 64'd50);
    check_idle("late_load_idle");

    // Reset mid-word after 7 beats, asserted between edges.
    @(negedge clk);
    load = 1'b1; din = Ones50;
    @(negedge clk);
    load = 1'b0; din = '0; sout_ready = 1'b1;
    repeat (7) @(negedge clk);
    check("mid_busy_before", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check_idle("mid_reset_async");
    sout_ready = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle("mid_reset_released");
    send_word(50'h1, 1'b0, 1'b0);
    check("post_reset_word", {14'd0, got_lsb}, 64'h1);
    check("post_reset_first", {63'd0, first_lsb}, 64'd1);
    check("post_reset_last_pos", 64'(last_pos), 64'd49);
    check_idle("post_reset_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
